// File: rtl/mem_req_ctrl.sv
// Request controller for the 8-entry, 256-bit scratch memory.
// Optional watchdog: define MEM_REQ_TIMEOUT_EN.
module mem_req_ctrl #(
  parameter int DATA_W   = 256,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 8,
  parameter int MIN_HOLD = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic              mem_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_served,
  output logic              busy
);

  localparam int HOLD_MAX =
    (MIN_HOLD > TIMEOUT) ? MIN_HOLD : TIMEOUT;
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_hold;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_we;
  logic                r_re;
  logic                r_en;

  state_t              w_state;
  logic [CNT_W-1:0]    w_hold;
  logic                w_write;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_err;
  logic                w_we;
  logic                w_re;
  logic                w_en;
  logic                w_oob;
  logic                w_done;
  logic                w_tmo;

  assign w_oob =
    ({1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH));

  // A served pulse only counts once the read path has settled.
  assign w_done = mem_served
    && (r_hold >= CNT_W'(MIN_HOLD));

`ifdef MEM_REQ_TIMEOUT_EN
  assign w_tmo =
    ({1'b0, r_hold} + 1'b1) >= (CNT_W + 1)'(TIMEOUT);
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state = r_state;
    w_hold  = r_hold;
    w_write = r_write;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rdata = r_rdata;
    w_err   = r_err;
    w_we    = r_we;
    w_re    = r_re;
    w_en    = r_en;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_write = req_write;
          w_addr  = req_addr;
          w_wdata = req_wdata;
          if (w_oob) begin
            w_state = S_RESP;
            w_err   = 1'b1;
            w_rdata = '0;
          end else begin
            w_state = S_ACCESS;
            w_hold  = '0;
            w_we    = req_write;
            w_re    = !req_write;
            w_en    = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (r_hold != CNT_W'(HOLD_MAX))
          w_hold = r_hold + 1'b1;
        if (w_done) begin
          w_rdata = r_write ? '0 : mem_data_out;
          w_err   = 1'b0;
          w_we    = 1'b0;
          w_re    = 1'b0;
          w_en    = 1'b0;
          w_state = S_RESP;
        end else if (w_tmo) begin
          w_rdata = '0;
          w_err   = 1'b1;
          w_we    = 1'b0;
          w_re    = 1'b0;
          w_en    = 1'b0;
          w_state = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state = S_IDLE;
          w_rdata = '0;
          w_err   = 1'b0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_we    = 1'b0;
        w_re    = 1'b0;
        w_en    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_hold  <= w_hold;
      r_write <= w_write;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
      r_err   <= w_err;
      r_we    <= w_we;
      r_re    <= w_re;
      r_en    <= w_en;
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign busy         = (r_state != S_IDLE);
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;
  assign mem_address  = r_addr;
  assign mem_data_in  = r_wdata;
  assign mem_write_en = r_we;
  assign mem_read_en  = r_re;
  assign mem_enable   = r_en;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a scratch memory model.
// Reference: array memory plus expected-response queue.
module tb_mem_req_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [4:0]   req_addr = '0;
  logic [255:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [255:0] rsp_rdata;
  logic         rsp_err;
  logic [4:0]   mem_address;
  logic [255:0] mem_data_in;
  logic         mem_write_en;
  logic         mem_read_en;
  logic         mem_enable;
  logic [255:0] mem_data_out = '0;
  logic         mem_served;
  logic         busy;

  mem_req_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_enable(mem_enable), .mem_data_out(mem_data_out),
    .mem_served(mem_served), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] init_val(input int i);
    logic [31:0] w;
    case (i)
      0: return 256'h33a344a3_0123456789abcdef0123456789abcdef0123456789abcdef_ea56a24a;
      1: return 256'hBFD6A48E497ACE3E68CEF97A5CE0E75340E85A30136F9E8ABC19C9860EEF5D4F;
      2: return 256'h988b6a57_fedcba9876543210fedcba9876543210fedcba9876543210_b8a93348;
      default: begin
        w = 32'(i) * 32'h9e3779b9;
        return {8{w}};
      end
    endcase
  endfunction

  // Memory model: level strobes, 2-stage read, served every 3 cycles
  logic [255:0] mem [8];
  logic [255:0] rd_stage = '0;
  int           scnt = 0;
  logic         served_en = 1'b1;

  assign mem_served = served_en && (scnt == 2);

  initial for (int i = 0; i < 8; i++) mem[i] = init_val(i);

  always @(posedge clk) begin
    scnt <= (scnt == 2) ? 0 : scnt + 1;
    if (mem_enable && mem_address < 5'd8) begin
      if (mem_write_en) mem[mem_address[2:0]] <= mem_data_in;
      rd_stage <= mem[mem_address[2:0]];
    end
    mem_data_out <= rd_stage;
  end

  // Reference model and scoreboard
  typedef struct {
    logic [255:0] rdata;
    logic         err;
  } exp_t;

  exp_t         expq[$];
  logic [255:0] ref_mem [8];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_rsp = 0;
  logic [255:0] last_rdata = '0;
  int           run = 0;
  int           maxrun = 0;
  int           strb_cyc = 0;
  logic         wr_seen = 1'b0;
  int           rdy_mode = 0;

  initial for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);

  function automatic void chk(input string nm,
                              input logic [255:0] act,
                              input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Accept side: compute the expected response from the request
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst) begin
      expq.delete();
    end else if (req_valid && req_ready) begin
      a = int'(req_addr);
      e.err = (a >= 8);
      e.rdata = '0;
      if (!e.err) begin
        if (req_write) ref_mem[a] = req_wdata;
        else e.rdata = ref_mem[a];
      end
`ifdef MEM_REQ_TIMEOUT_EN
      if (!served_en && !e.err) begin
        e.err = 1'b1;
        e.rdata = '0;
      end
`endif
      expq.push_back(e);
    end
  end

  // Response side: pop and compare on every handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rdata %h err %b want none",
                 rsp_rdata, rsp_err);
      end else begin
        e = expq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 256'(rsp_err), 256'(e.err));
        n_rsp++;
        last_rdata = rsp_rdata;
      end
    end
  end

  // Strobe activity tracking
  always @(negedge clk) begin
    if (mem_read_en || mem_write_en) begin
      run++;
      strb_cyc++;
      if (run > maxrun) maxrun = run;
      chk("enable_with_strobe", 256'(mem_enable), 256'(1));
    end else begin
      run = 0;
    end
    if (mem_write_en) wr_seen = 1'b1;
    if (mem_enable && !(mem_read_en || mem_write_en)) strb_cyc++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom % 2);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic w, input logic [4:0] a,
                      input logic [255:0] d);
    bit ok = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready && !rst;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no accept want accept addr %0d", a);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (expq.size() == 0) && !rsp_valid && !busy;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: got busy %b queue %0d want idle",
               busy, expq.size());
    end
  endtask

  initial begin
    int k;
    int r0;
    int bad_busy;
    int bad_vld;
    logic [255:0] d;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 256'(req_ready), 256'(1));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_strobes",
        256'({mem_read_en, mem_write_en, mem_enable}), 256'(0));
    chk("rst_rdata_err", {rsp_rdata[254:0], rsp_err}, 256'(0));

    // Read addr 1 with power-up contents
    maxrun = 0;
    wr_seen = 1'b0;
    r0 = n_rsp;
    send(1'b0, 5'd1, '0);
    wait_idle();
    chk("rd1_count", 256'(n_rsp - r0), 256'(1));
    chk("rd1_data", last_rdata,
        256'hBFD6A48E497ACE3E68CEF97A5CE0E75340E85A30136F9E8ABC19C9860EEF5D4F);
    chk("rd1_hold_ge3", 256'(maxrun >= 3), 256'(1));
    chk("rd1_no_write", 256'(wr_seen), 256'(0));

    // Write then read addr 7
    send(1'b1, 5'd7, 256'hDEADBEEF);
    wait_idle();
    chk("wr7_rdata", last_rdata, 256'(0));
    send(1'b0, 5'd7, '0);
    wait_idle();
    chk("rd7_data", last_rdata, 256'hDEADBEEF);

    // Out-of-range addresses
    strb_cyc = 0;
    send(1'b0, 5'd9, '0);
    @(negedge clk);
    chk("err9_valid", 256'(rsp_valid), 256'(1));
    chk("err9_err", 256'(rsp_err), 256'(1));
    chk("err9_rdata", rsp_rdata, 256'(0));
    wait_idle();
    send(1'b1, 5'd8, {8{32'hA5A5_5A5A}});
    @(negedge clk);
    chk("err8_valid", 256'(rsp_valid), 256'(1));
    chk("err8_err", 256'(rsp_err), 256'(1));
    wait_idle();
    chk("err_no_strobes", 256'(strb_cyc), 256'(0));

    // Response back-pressure on addr 0
    rdy_mode = 2;
    send(1'b0, 5'd0, '0);
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("hold_valid_seen", 256'(rsp_valid), 256'(1));
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 256'(rsp_valid), 256'(1));
      chk("hold_rdata", rsp_rdata, init_val(0));
      chk("hold_req_ready", 256'(req_ready), 256'(0));
      if (i == 4) rdy_mode = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 5'd2;
    end
    @(negedge clk);
    chk("hs_req_ready", 256'(req_ready), 256'(0));
    @(negedge clk);
    chk("post_hs_req_ready", 256'(req_ready), 256'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_idle();
    chk("post_hs_rd2", last_rdata, init_val(2));

    // Reset in the middle of an access
    r0 = n_rsp;
    send(1'b0, 5'd3, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobes",
        256'({mem_read_en, mem_write_en, mem_enable}), 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    bad_vld = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) bad_vld++;
    end
    chk("mid_rst_no_rsp", 256'(bad_vld), 256'(0));
    chk("mid_rst_rsp_cnt", 256'(n_rsp - r0), 256'(0));
    send(1'b0, 5'd2, '0);
    wait_idle();
    chk("after_rst_rd2", last_rdata,
        256'h988b6a57_fedcba9876543210fedcba9876543210fedcba9876543210_b8a93348);

    // Memory never serves
    @(posedge clk);
    #1;
    served_en = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    maxrun = 0;
    send(1'b0, 5'd5, '0);
    wait_idle();
    chk("tmo_cycles", 256'(maxrun), 256'(16));
    @(posedge clk);
    #1;
    served_en = 1'b1;
`else
    send(1'b0, 5'd5, '0);
    bad_busy = 0;
    bad_vld = 0;
    repeat (100) begin
      @(negedge clk);
      if (!busy) bad_busy++;
      if (rsp_valid) bad_vld++;
    end
    chk("stall_busy", 256'(bad_busy), 256'(0));
    chk("stall_no_rsp", 256'(bad_vld), 256'(0));
    @(posedge clk);
    #1;
    served_en = 1'b1;
    wait_idle();
    chk("stall_recover", last_rdata, init_val(5));
`endif

    // Random traffic with random back-pressure
    rdy_mode = 1;
    r0 = n_rsp;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      send(1'($urandom % 2), 5'($urandom_range(0, 11)), d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();
    chk("rand_rsp_count", 256'(n_rsp - r0), 256'(40));
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
